mdio_speed_poller: RTL and testbench

MDIO_SPEED_POLLER -- requirements
Module: mdio_speed_poller

---
 rtl/mdio_speed_poller_if.sv | 10 +
 rtl/mdio_speed_poller.sv | 183 ++++++++++++++++++
 tb/tb_mdio_speed_poller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_speed_poller_if.sv
// MDIO master pin bundle: clock, data out, tri-state enable (1 = released) and data in.
interface mdio_speed_poller_if;
  logic mdc;
  logic mdio_o;
  logic mdio_t;
  logic mdio_i;

  modport master (output mdc, output mdio_o, output mdio_t, input mdio_i);
  modport slave  (input mdc, input mdio_o, input mdio_t, output mdio_i);
endinterface

// File: rtl/mdio_speed_poller.sv
// Periodically reads PHY BMSR and a vendor speed register over MDIO and reports
// link state plus the resolved 2-bit speed code for the RGMII block.
module mdio_speed_poller #(
  parameter int         CLK_DIV       = 25,
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] SPEED_REG     = 5'h11,
  parameter int         SPEED_LSB     = 14,
  parameter int         POLL_INTERVAL = 1250000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  mdio_speed_poller_if.master        mdio,
  output logic [1:0]                 speed,
  output logic                       link_up,
  output logic                       speed_change,
  output logic                       mdio_err,
  output logic                       busy
);

  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam int         TMR_W    = $clog2(POLL_INTERVAL + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, RD_BMSR, RD_SPD, UPDATE, WAIT} state_t;

  state_t           state_reg, state_next;
  logic [8:0]       div_reg, div_next;
  logic [5:0]       bit_reg, bit_next;
  logic             active_reg, active_next;
  logic [15:0]      data_reg, data_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             link_seen_reg, link_seen_next;
  logic [1:0]       speed_reg, speed_next;
  logic             link_up_reg, link_up_next;
  logic             speed_change_reg, speed_change_next;
  logic             mdio_err_reg, mdio_err_next;

  logic        sample;
  logic        frame_last;
  logic        ta_abort;
  logic [1:0]  field;
  logic [4:0]  reg_addr;
  logic [13:0] hdr;
  logic [3:0]  hdr_idx;

  assign sample     = active_reg && (div_reg == DIV_HALF);
  assign frame_last = active_reg && (bit_reg == 6'd63) && (div_reg == DIV_LAST);
  // Turnaround bit 47 must be driven low by the PHY; a released (high) line means no PHY.
  assign ta_abort   = sample && (bit_reg == 6'd47) && mdio.mdio_i;
  assign field      = data_reg[SPEED_LSB +: 2];
  assign reg_addr   = (state_reg == RD_SPD) ? SPEED_REG : 5'd1;
  assign hdr        = {4'b0110, PHY_ADDR, reg_addr};
  assign hdr_idx    = 4'(6'd45 - bit_reg);

  assign mdio.mdc    = active_reg && (div_reg >= DIV_HALF);
  assign mdio.mdio_t = !(active_reg && (bit_reg < 6'd46));
  assign mdio.mdio_o = (active_reg && (bit_reg >= 6'd32) && (bit_reg <= 6'd45)) ? hdr[hdr_idx] : 1'b1;

  assign speed        = speed_reg;
  assign link_up      = link_up_reg;
  assign speed_change = speed_change_reg;
  assign mdio_err     = mdio_err_reg;
  assign busy         = (state_reg == RD_BMSR) || (state_reg == RD_SPD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      div_reg          <= '0;
      bit_reg          <= '0;
      active_reg       <= 1'b0;
      data_reg         <= '0;
      tmr_reg          <= '0;
      link_seen_reg    <= 1'b0;
      speed_reg        <= 2'b10;
      link_up_reg      <= 1'b0;
      speed_change_reg <= 1'b0;
      mdio_err_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      div_reg          <= div_next;
      bit_reg          <= bit_next;
      active_reg       <= active_next;
      data_reg         <= data_next;
      tmr_reg          <= tmr_next;
      link_seen_reg    <= link_seen_next;
      speed_reg        <= speed_next;
      link_up_reg      <= link_up_next;
      speed_change_reg <= speed_change_next;
      mdio_err_reg     <= mdio_err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    div_next          = div_reg;
    bit_next          = bit_reg;
    active_next       = active_reg;
    data_next         = data_reg;
    tmr_next          = tmr_reg;
    link_seen_next    = link_seen_reg;
    speed_next        = speed_reg;
    link_up_next      = link_up_reg;
    speed_change_next = 1'b0;
    mdio_err_next     = 1'b0;

    // Bit clocking runs independently of the FSM so an aborted frame still drains.
    if (active_reg) begin
      if (div_reg == DIV_LAST) begin
        div_next = '0;
        bit_next = bit_reg + 6'd1;
      end else begin
        div_next = div_reg + 9'd1;
      end
      if (sample && (bit_reg >= 6'd48))
        data_next = {data_reg[14:0], mdio.mdio_i};
      if (frame_last)
        active_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next  = RD_BMSR;
          active_next = 1'b1;
          div_next    = '0;
          bit_next    = '0;
        end
      end
      RD_BMSR, RD_SPD: begin
        if (ta_abort) begin
          state_next        = WAIT;
          tmr_next          = '0;
          link_up_next      = 1'b0;
          speed_change_next = link_up_reg;
          mdio_err_next     = 1'b1;
        end else if (frame_last) begin
          if ((state_reg == RD_BMSR) && data_reg[2]) begin
            state_next  = RD_SPD;
            active_next = 1'b1;
          end else begin
            state_next     = UPDATE;
            link_seen_next = (state_reg == RD_SPD);
          end
        end
      end
      UPDATE: begin
        if (link_seen_reg) begin
          link_up_next = 1'b1;
          if (field == 2'b11)
            mdio_err_next = 1'b1;
          else
            speed_next = field;
        end else begin
          link_up_next = 1'b0;
        end
        speed_change_next = (link_up_next != link_up_reg) || (speed_next != speed_reg);
        tmr_next          = '0;
        state_next        = enable ? WAIT : IDLE;
      end
      WAIT: begin
        if (!active_reg) begin
          if (tmr_reg == TMR_LAST) begin
            tmr_next = '0;
            if (enable) begin
              state_next  = RD_BMSR;
              active_next = 1'b1;
              div_next    = '0;
              bit_next    = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdio_speed_poller.sv
// Directed bench for mdio_speed_poller with a behavioural PHY on the MDIO pins.
module tb_mdio_speed_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] speed;
  logic       link_up, speed_change, mdio_err, busy;

  int total = 0;
  int bad   = 0;

  mdio_speed_poller_if mdio ();

  always #5 clk = ~clk;

  mdio_speed_poller #(
    .CLK_DIV(2), .PHY_ADDR(5'd0), .SPEED_REG(5'h11), .SPEED_LSB(14), .POLL_INTERVAL(100)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mdio(mdio.master),
    .speed(speed), .link_up(link_up), .speed_change(speed_change),
    .mdio_err(mdio_err), .busy(busy)
  );

  // PHY model state
  logic [15:0] bmsr_val = 16'h0004;
  logic [15:0] spd_val  = 16'h8000;
  logic        absent   = 1'b0;
  int          phy_bit  = 64;
  logic [45:0] cap      = '0;
  logic [4:0]  phy_reg  = '0;
  logic        mdio_i_drv = 1'b1;
  logic        prev_mdc = 1'b0;
  logic        prev_t   = 1'b1;
  int          cyc = 0, last_rise = 0, frame_gap = 0;
  int          n_bmsr = 0, n_spd = 0, sc_cnt = 0, err_cnt = 0, rise_cnt = 0, busy_cnt = 0;
  logic [45:0] bmsr_frame = '0, spd_frame = '0;

  assign mdio.mdio_i = mdio_i_drv;

  function automatic logic phy_val(input int b, input logic [15:0] d, input logic abs);
    if (abs) return 1'b1;
    if (b == 47) return 1'b0;
    if (b >= 48 && b <= 63) return d[63 - b];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_mdc <= mdio.mdc;
    prev_t   <= mdio.mdio_t;
    if (speed_change) sc_cnt   <= sc_cnt + 1;
    if (mdio_err)     err_cnt  <= err_cnt + 1;
    if (busy)         busy_cnt <= busy_cnt + 1;
    if (rst) begin
      phy_bit <= 64;
    end else if (!mdio.mdio_t && prev_t) begin
      phy_bit <= 0;
    end else if (mdio.mdc && !prev_mdc) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
      if (phy_bit < 46) cap[45 - phy_bit] <= mdio.mdio_o;
      if (phy_bit == 45) begin
        phy_reg <= {cap[4:1], mdio.mdio_o};
        if ({cap[4:1], mdio.mdio_o} == 5'd1) begin
          n_bmsr     <= n_bmsr + 1;
          bmsr_frame <= {cap[45:1], mdio.mdio_o};
          frame_gap  <= cyc - last_rise;
        end else if ({cap[4:1], mdio.mdio_o} == 5'h11) begin
          n_spd     <= n_spd + 1;
          spd_frame <= {cap[45:1], mdio.mdio_o};
        end
      end
      phy_bit <= phy_bit + 1;
    end
    if (!mdio.mdc)
      mdio_i_drv <= phy_val(phy_bit, (phy_reg == 5'd1) ? bmsr_val : spd_val, absent);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max, output int n);
    n = 0;
    while (busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) n = -1;
  endtask

  task automatic do_poll(input string tag);
    int n;
    wait_busy(1'b1, 400, n);
    check({tag, "_start"}, 64'(n != -1), 64'd1);
    wait_busy(1'b0, 700, n);
    check({tag, "_end"}, 64'(n != -1), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b_sc, b_err, b_bmsr, b_spd, b_rise, b_busy, t_low;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_mdc",    64'(mdio.mdc),     64'd0);
    check("rst_mdio_o", 64'(mdio.mdio_o),  64'd1);
    check("rst_mdio_t", 64'(mdio.mdio_t),  64'd1);
    check("rst_speed",  64'(speed),        64'd2);
    check("rst_link",   64'(link_up),      64'd0);
    check("rst_sc",     64'(speed_change), 64'd0);
    check("rst_err",    64'(mdio_err),     64'd0);
    check("rst_busy",   64'(busy),         64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy",   64'(busy),        64'd0);
    check("idle_mdio_t", 64'(mdio.mdio_t), 64'd1);

    // First poll: 1G, link up
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", 64'(busy), 64'd1);
    do_poll("p1");
    check("p1_speed",     64'(speed),   64'd2);
    check("p1_link",      64'(link_up), 64'd1);
    check("p1_sc",        64'(sc_cnt),  64'd1);
    check("p1_err",       64'(err_cnt), 64'd0);
    check("p1_nbmsr",     64'(n_bmsr),  64'd1);
    check("p1_nspd",      64'(n_spd),   64'd1);
    check("p1_preamble",  64'(bmsr_frame[45:14]), 64'hFFFF_FFFF);
    check("p1_bmsr_hdr",  64'(bmsr_frame[13:0]),  64'(14'b01_10_00000_00001));
    check("p1_spd_hdr",   64'(spd_frame[13:0]),   64'(14'b01_10_00000_10001));
    check("p1_mdc_period", 64'(frame_gap), 64'd4);

    // Speed change to 100M
    spd_val = 16'h4000;
    b_sc = sc_cnt;
    do_poll("p2");
    check("p2_speed", 64'(speed),       64'd1);
    check("p2_sc",    64'(sc_cnt - b_sc), 64'd1);
    check("p2_link",  64'(link_up),     64'd1);

    // Same data again: no pulse
    b_sc = sc_cnt; b_spd = n_spd;
    do_poll("p3");
    check("p3_sc",    64'(sc_cnt - b_sc), 64'd0);
    check("p3_speed", 64'(speed),         64'd1);
    check("p3_nspd",  64'(n_spd - b_spd), 64'd1);

    // Link loss
    bmsr_val = 16'h0000;
    b_sc = sc_cnt; b_spd = n_spd; b_bmsr = n_bmsr;
    do_poll("p4");
    check("p4_link",  64'(link_up),         64'd0);
    check("p4_speed", 64'(speed),           64'd1);
    check("p4_nspd",  64'(n_spd - b_spd),   64'd0);
    check("p4_nbmsr", 64'(n_bmsr - b_bmsr), 64'd1);
    check("p4_sc",    64'(sc_cnt - b_sc),   64'd1);

    bmsr_val = 16'h0004;
    do_poll("p5");
    check("p5_link", 64'(link_up), 64'd1);

    // Absent PHY
    absent = 1'b1;
    b_sc = sc_cnt; b_err = err_cnt;
    wait_busy(1'b1, 400, n);
    check("ab_start", 64'(n != -1), 64'd1);
    n = 0;
    while (!mdio_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ab_err_time", 64'(n),       64'd191);
    check("ab_busy",     64'(busy),    64'd0);
    check("ab_link",     64'(link_up), 64'd0);
    @(negedge clk);
    check("ab_err_pulse", 64'(mdio_err), 64'd0);
    b_rise = rise_cnt;
    n = 1;
    while (!busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ab_next_poll", 64'(n),                 64'd165);
    check("ab_drain_mdc", 64'(rise_cnt - b_rise), 64'd16);
    check("ab_sc",        64'(sc_cnt - b_sc),     64'd1);
    check("ab_errcnt",    64'(err_cnt - b_err),   64'd1);
    check("ab_speed",     64'(speed),             64'd1);

    // Reserved speed field
    wait_busy(1'b0, 400, n);
    check("rs_abort", 64'(n != -1), 64'd1);
    repeat (3) @(negedge clk);
    absent = 1'b0;
    spd_val = 16'hC000;
    b_sc = sc_cnt; b_err = err_cnt;
    do_poll("rs");
    check("rs_link",  64'(link_up),         64'd1);
    check("rs_speed", 64'(speed),           64'd1);
    check("rs_err",   64'(err_cnt - b_err), 64'd1);
    check("rs_sc",    64'(sc_cnt - b_sc),   64'd1);

    // Reset mid-frame at bit 40
    wait_busy(1'b1, 400, n);
    check("mr_start", 64'(n != -1), 64'd1);
    repeat (160) @(negedge clk);
    check("mr_pre_link", 64'(link_up), 64'd1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("mr_mdc",    64'(mdio.mdc),    64'd0);
    check("mr_mdio_t", 64'(mdio.mdio_t), 64'd1);
    check("mr_speed",  64'(speed),       64'd2);
    check("mr_link",   64'(link_up),     64'd0);
    check("mr_busy",   64'(busy),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    t_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mdio.mdio_t !== 1'b1) t_low++;
    end
    check("mr_post_t", 64'(t_low), 64'd0);

    // enable falls mid-frame
    spd_val = 16'h4000;
    enable = 1'b1;
    b_sc = sc_cnt; b_spd = n_spd;
    wait_busy(1'b1, 400, n);
    check("ef_start", 64'(n != -1), 64'd1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, 700, n);
    check("ef_end", 64'(n != -1), 64'd1);
    repeat (4) @(negedge clk);
    check("ef_speed", 64'(speed),         64'd1);
    check("ef_link",  64'(link_up),       64'd1);
    check("ef_nspd",  64'(n_spd - b_spd), 64'd1);
    check("ef_sc",    64'(sc_cnt - b_sc), 64'd1);
    b_busy = busy_cnt; b_bmsr = n_bmsr;
    repeat (300) @(negedge clk);
    check("ef_idle_busy", 64'(busy_cnt - b_busy), 64'd0);
    check("ef_idle_nbmsr", 64'(n_bmsr - b_bmsr),  64'd0);
    check("ef_hold_speed", 64'(speed),            64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
